// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package loader_pkg;

    typedef enum logic [2:0] {
        SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned LANES     = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = BYTE_W * LANES;
    localparam int unsigned LEN_W     = 16;

    // States during which a frame is being received and the idle timeout runs.
    function automatic logic in_frame(input loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
interface imem_loader_if
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) ();

    logic                  rx_valid;
    logic [BYTE_W-1:0]     rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WORD_W-1:0]     imem_wdata;

    // master: byte source / memory observer; slave: the loader itself
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/loader_word_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words and pulses word_valid
// the cycle after the fourth byte of each word.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_done_c,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane;

    assign word_done_c = byte_valid && (lane == LANE_W'(LANES - 1));

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= word_done_c;
            if (clear) begin
                lane <= '0;
            end else if (byte_valid) begin
                lane <= lane + LANE_W'(1);
                word <= {byte_data, word[WORD_W-1:BYTE_W]};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes words into instruction memory and
// holds the core in reset until a frame completes. Define LOADER_CHECKSUM_EN to
// require a trailing XOR checksum byte after the payload.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus,
    output logic         cpu_reset_n,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    loader_state_t         state, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BYTE_W-1:0]     chk_q, chk_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  busy_d, done_d, error_d, cpu_reset_n_d;

    logic                  hs_c;
    logic                  asm_clear_c;
    logic                  asm_valid_c;
    logic                  word_done_c;
    logic                  word_valid;
    logic [WORD_W-1:0]     word;
    logic [LEN_W-1:0]      n_c;
    logic                  last_word_c;

    assign hs_c        = bus.rx_valid && rx_ready_q;
    assign n_c         = {bus.rx_data, len_q[BYTE_W-1:0]};
    assign last_word_c = (32'(addr_q) + 32'd1) == 32'(len_q);

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word;

    loader_word_assembler u_asm (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (asm_clear_c),
        .byte_valid  (asm_valid_c),
        .byte_data   (bus.rx_data),
        .word_done_c (word_done_c),
        .word_valid  (word_valid),
        .word        (word)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            len_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            rx_ready_q  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
        end else begin
            state       <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            rx_ready_q  <= rx_ready_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            cpu_reset_n <= cpu_reset_n_d;
        end
    end

    // Next-state and next-output logic; status outputs follow the next state
    // so they change on the same edge as the state itself.
    always_comb begin
        state_d     = state;
        len_d       = len_q;
        addr_d      = addr_q;
        chk_d       = chk_q;
        asm_clear_c = 1'b0;
        asm_valid_c = 1'b0;
        cnt_d       = (in_frame(state) && !hs_c) ? cnt_q + CNT_W'(1) : '0;

        case (state)
            SYNC, DONE, ERROR: begin
                if (hs_c && (bus.rx_data == SYNC_BYTE)) begin
                    state_d     = LEN_LO;
                    len_d       = '0;
                    addr_d      = '0;
                    chk_d       = '0;
                    asm_clear_c = 1'b1;
                end
            end
            LEN_LO: begin
                if (hs_c) begin
                    len_d   = LEN_W'(bus.rx_data);
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (hs_c) begin
                    len_d = n_c;
                    chk_d = chk_q ^ bus.rx_data;
                    if (n_c == '0) begin
                        state_d = CHK_EN ? CHECK : DONE;
                    end else if (32'(n_c) > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                asm_valid_c = hs_c;
                if (hs_c) begin
                    chk_d = chk_q ^ bus.rx_data;
                end
                if (word_valid) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (last_word_c) begin
                        state_d = CHK_EN ? CHECK : DONE;
                    end
                end
            end
            CHECK: begin
                if (hs_c) begin
                    state_d = (bus.rx_data == chk_q) ? DONE : ERROR;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        if (in_frame(state) && !hs_c && (cnt_q == CNT_LAST)) begin
            state_d = ERROR;
        end

        // The cycle of each memory write is the only one that refuses bytes.
        rx_ready_d    = !word_done_c;
        busy_d        = in_frame(state_d);
        done_d        = (state_d == DONE);
        error_d       = (state_d == ERROR);
        cpu_reset_n_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: driver queues expected writes from a
// frame-level model, an independent monitor checks every imem_we pulse.
module tb_imem_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned TO = 100;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset_n;
    logic cpu_reset_n, busy, done, error;

    int total = 0;
    int bad   = 0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.imem_we === 1'b1) begin
            check("rx_ready_low_on_write", 32'(bus.rx_ready), 32'd0);
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %h want no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                int          a;
                logic [31:0] d;
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                check("write_addr", 32'(bus.imem_addr), 32'(a));
                check("write_data", bus.imem_wdata, d);
            end
        end
    end

    // Frame-level reference: locate sync, read N, emit words, judge the frame.
    task automatic model_frame(input bq_t q, output bit e_done, output bit e_err);
        int          i;
        int          n;
        int          base;
        logic [7:0]  c;
        logic [31:0] w;
        e_done = 1'b0;
        e_err  = 1'b0;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        n    = int'(q[i+1]) + 256 * int'(q[i+2]);
        c    = q[i+1] ^ q[i+2];
        base = i + 3;
        if (n > (1 << AW)) begin
            e_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'(q[base+4*k]) + (32'(q[base+4*k+1]) << 8) +
                (32'(q[base+4*k+2]) << 16) + (32'(q[base+4*k+3]) << 24);
            exp_addr.push_back(k);
            exp_data.push_back(w);
            c = c ^ q[base+4*k] ^ q[base+4*k+1] ^ q[base+4*k+2] ^ q[base+4*k+3];
        end
        if (CHK_EN) begin
            if (q[base+4*n] == c) e_done = 1'b1;
            else                  e_err  = 1'b1;
        end else begin
            e_done = 1'b1;
        end
    endtask

    function automatic bq_t with_chk(input bq_t q);
        logic [7:0] c;
        bq_t r;
        r = q;
        if (CHK_EN) begin
            c = 8'h00;
            for (int k = 1; k < q.size(); k++) c = c ^ q[k];
            r.push_back(c);
        end
        return r;
    endfunction

    // Called and returns at a falling edge; handshake happens on the rising edge in between.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rx_ready_wait: got rx_ready=%b want 1 within 20 cycles", bus.rx_ready);
        end else begin
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit e_done, input bit e_err);
        check({tag, "_done"}, 32'(done), 32'(e_done));
        check({tag, "_error"}, 32'(error), 32'(e_err));
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(e_done));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_writes_drained"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bq_t q, input int gap_max);
        bit e_done, e_err;
        model_frame(q, e_done, e_err);
        foreach (q[k]) send_byte(q[k], $urandom_range(0, gap_max));
        repeat (3) @(negedge clk);
        check_status(tag, e_done, e_err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t q;
        bq_t g;
        bit  e_done, e_err;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Two-word program
        q = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
        run_frame("two_words", with_chk(q), 0);

        // Empty program
        q = '{8'hA5, 8'h00, 8'h00};
        run_frame("empty", with_chk(q), 1);

        // Length one past the memory size
        q = '{8'hA5, 8'h01, 8'h04};
        model_frame(q, e_done, e_err);
        foreach (q[k]) send_byte(q[k], 0);
        check("len_over_error_now", 32'(error), 32'd1);
        check("len_over_cpu_reset", 32'(cpu_reset_n), 32'd0);
        check_status("len_over", e_done, e_err);

        // Idle timeout mid-word
        q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        foreach (q[k]) send_byte(q[k], 0);
        repeat (TO - 1) @(negedge clk);
        check("timeout_before_busy", 32'(busy), 32'd1);
        check("timeout_before_error", 32'(error), 32'd0);
        @(negedge clk);
        check("timeout_at_error", 32'(error), 32'd1);
        repeat (100) @(negedge clk);
        check_status("timeout", 1'b0, 1'b1);

        // Full-size program (exactly 2**AW words)
        q = '{8'hA5, 8'h00, 8'h04};
        for (int k = 0; k < 4 * (1 << AW); k++) q.push_back(8'($urandom));
        run_frame("max_len", with_chk(q), 0);

        if (CHK_EN) begin
            q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
            run_frame("bad_chk", q, 0);
            q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
            run_frame("good_after_bad", with_chk(q), 0);
        end

        // Reset asserted in the middle of DATA
        q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_addr.push_back(0);
        exp_data.push_back(32'h44332211);
        foreach (q[k]) send_byte(q[k], 0);
        check("mid_reset_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_reset_drained", 32'(exp_addr.size()), 32'd0);

        // Garbage before sync, then a normal frame
        q = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        g = '{8'h00, 8'hFF, 8'h5A};
        q = with_chk(q);
        foreach (q[k]) g.push_back(q[k]);
        run_frame("after_reset", g, 2);

        // Randomized frames with garbage, random gaps and occasional bad checksums
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 6);
            g = {};
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                g.push_back(b);
            end
            q = '{8'hA5, 8'(n), 8'h00};
            for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
            q = with_chk(q);
            if (CHK_EN && ($urandom_range(0, 3) == 0)) begin
                q[q.size()-1] = q[q.size()-1] ^ 8'h01;
            end
            foreach (q[k]) g.push_back(q[k]);
            run_frame("random", g, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
